sdp_ram_arbiter: RTL
====================

SDP_RAM_ARBITER -- requirements
Module: sdp_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the shared RAM.
REQ-002 Parameter ADDR_WIDTH, default 6, RAM depth is 2**ADDR_WIDTH words.
REQ-003 Parameter NUM_REQ, default 2, number of requesters per port; legal range 2..4.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 wr_req  in  NUM_REQ  per-requester write request, held until granted.
REQ-007 wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i at slice i.
REQ-008 wr_data  in  NUM_REQ*DATA_WIDTH  packed write data; requester i at slice i.
REQ-009 wr_gnt  out  NUM_REQ  one-hot write grant, same cycle as the accepted request.
REQ-010 rd_req  in  NUM_REQ  per-requester read request, held until granted.
REQ-011 rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
REQ-012 rd_gnt  out  NUM_REQ  one-hot read grant.
REQ-013 rd_valid  out  1  read data valid.
REQ-014 rd_id  out  2  index of the requester owning rd_data.
REQ-015 rd_data  out  DATA_WIDTH  read data.
REQ-016 clr_start  in  1  single-cycle pulse that starts a zero-fill of the whole RAM.
REQ-017 busy  out  1  high while the zero-fill runs.

Function
REQ-018 Write port and read port SHALL be arbitrated independently; one write and one read grant SHALL be allowed in the same cycle.
REQ-019 Each port SHALL use round-robin: search starts at the port's pointer; after a grant to i, the pointer SHALL become (i+1) mod NUM_REQ; with no grant, the pointer SHALL hold.
REQ-020 Grants SHALL be combinational from req and pointer, at most one bit high per port, never to a requester whose req is low.
REQ-021 A write grant to i SHALL drive RAM we=1, waddr=wr_addr[i], d=wr_data[i] in the same cycle.
REQ-022 A read grant to i SHALL drive RAM raddr=rd_addr[i]; one cycle later rd_valid=1, rd_id=i, rd_data=RAM word (latency exactly 1).
REQ-023 rd_valid SHALL be high for exactly one cycle per read grant; back-to-back grants SHALL give back-to-back valids.
REQ-024 Read and write to the same address in one cycle SHALL return the old word; no forwarding.
REQ-025 FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after writing address 2**ADDR_WIDTH-1.
REQ-026 In CLEAR, a counter SHALL start at 0, write zero to counter address each cycle, and increment; the fill takes 2**ADDR_WIDTH cycles.
REQ-027 In CLEAR, wr_gnt and rd_gnt SHALL be all-zero and busy=1; pointers SHALL hold.
REQ-028 clr_start during CLEAR SHALL be ignored; the counter SHALL not restart.
REQ-029 A read granted in the cycle clr_start is sampled SHALL still complete with its rd_valid.
REQ-030 rd_data SHALL hold its last value while rd_valid=0.

Reset
REQ-031 On rst: state IDLE, counter 0, both pointers 0, rd_valid 0, rd_id 0, busy 0.
REQ-032 Reset mid-CLEAR SHALL abort the fill; RAM contents are undefined from the user's view.
REQ-033 A read granted in the cycle rst is high SHALL not produce rd_valid.
REQ-034 Reset SHALL not clear RAM contents; rd_data after reset is undefined until the first rd_valid.

Structure
REQ-035 The state encoding (IDLE, CLEAR) and the NUM_REQ upper bound of 4 SHALL be in the shared package.
REQ-036 The block SHALL instantiate one sdp_ram (OUT_NEW_DATA=0, IMPORT=0) as its only sub-module.
REQ-037 One round-robin function/task SHALL be reused for both ports.

Verification
REQ-038 NUM_REQ=2, wr_req=2'b11 held 4 cycles, pointer 0 -> wr_gnt 01,10,01,10.
REQ-039 Write 0xDEADBEEF to addr 5 by req1, then read addr 5 by req0 -> rd_valid one cycle after rd_gnt, rd_id=0, rd_data=0xDEADBEEF.
REQ-040 Same cycle: write 0x1 and read to addr 3 holding 0x0 -> rd_data=0x0; next read of addr 3 -> 0x1.
REQ-041 Fill RAM with nonzero, pulse clr_start -> busy for 64 cycles, no grants, second clr_start at cycle 10 ignored; then all 64 reads return 0.
REQ-042 Assert rst at cycle 20 of CLEAR -> busy=0, state IDLE, pointers 0 next cycle; a read granted with rst high gives no rd_valid.
REQ-043 Random wr_req/rd_req with scoreboard, 10k cycles -> no lost or duplicate rd_valid; each requester granted within NUM_REQ cycles of a held request.

Source files
------------

// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared types for the dual-port RAM arbiter: FSM encoding, requester bound
// and the round-robin pick used by both the write and read ports.
package sdp_ram_arbiter_pkg;

   localparam int MAX_REQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } rr_pick_t;

   // Descending scan so the last match written is the one closest to ptr.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [1:0]         ptr,
                                        input int                 num);
      rr_pick_t res;
      int       j;
      res = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < num) begin
            j = (int'(ptr) + k) % num;
            if (req[j]) begin
               res.hit = 1'b1;
               res.idx = 2'(j);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write and one read port, registered read data.
// OUT_NEW_DATA selects write-through on collision; IMPORT registers the inputs.
module sdp_ram #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 6,
   parameter int OUT_NEW_DATA = 0,
   parameter int IMPORT       = 0
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] d,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic                  we_s;
   logic                  re_s;
   logic [ADDR_WIDTH-1:0] waddr_s;
   logic [ADDR_WIDTH-1:0] raddr_s;
   logic [DATA_WIDTH-1:0] d_s;

   if (IMPORT != 0) begin : g_in_reg
      always_ff @(posedge clk) begin
         we_s    <= we;
         re_s    <= re;
         waddr_s <= waddr;
         raddr_s <= raddr;
         d_s     <= d;
      end
   end else begin : g_in_direct
      assign we_s    = we;
      assign re_s    = re;
      assign waddr_s = waddr;
      assign raddr_s = raddr;
      assign d_s     = d;
   end

   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[waddr_s] <= d_s;
      end
      if (re_s) begin
         if (OUT_NEW_DATA != 0 && we_s && waddr_s == raddr_s) begin
            q <= d_s;
         end else begin
            q <= mem[raddr_s];
         end
      end
   end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Round-robin arbitration of NUM_REQ writers and NUM_REQ readers onto one
// simple dual-port RAM, with a sequenced zero-fill of the whole array.
//
//   state    | meaning
//   ST_IDLE  | normal arbitration of both ports
//   ST_CLEAR | zero-fill walking every address, all grants blocked
module sdp_ram_arbiter
   import sdp_ram_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REQ    = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               wr_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
   output logic [NUM_REQ-1:0]               wr_gnt,
   input  logic [NUM_REQ-1:0]               rd_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
   output logic [NUM_REQ-1:0]               rd_gnt,
   output logic                             rd_valid,
   output logic [1:0]                       rd_id,
   output logic [DATA_WIDTH-1:0]            rd_data,
   input  logic                             clr_start,
   output logic                             busy
);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic                  rd_valid_q;
   logic [1:0]            rd_id_q;
   logic                  busy_q;

   rr_pick_t              wr_pick, rd_pick;
   logic                  ram_we, ram_re;
   logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
   logic [DATA_WIDTH-1:0] ram_d;

   always_comb begin
      wr_pick   = rr_pick(MAX_REQ'(wr_req), wr_ptr_q, NUM_REQ);
      rd_pick   = rr_pick(MAX_REQ'(rd_req), rd_ptr_q, NUM_REQ);
      wr_gnt    = '0;
      rd_gnt    = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_d     = '0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (state_q == ST_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_cnt_q;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_pick.hit && wr_pick.idx == 2'(i)) begin
               wr_gnt[i] = 1'b1;
               ram_we    = 1'b1;
               ram_waddr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               ram_d     = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
               wr_ptr_d  = (i == NUM_REQ - 1) ? 2'd0 : 2'(i + 1);
            end
            if (rd_pick.hit && rd_pick.idx == 2'(i)) begin
               rd_gnt[i] = 1'b1;
               ram_re    = 1'b1;
               ram_raddr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               rd_ptr_d  = (i == NUM_REQ - 1) ? 2'd0 : 2'(i + 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         clr_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= ram_re;
         if (ram_re) begin
            rd_id_q <= rd_pick.idx;
         end
         case (state_q)
            ST_IDLE: begin
               if (clr_start) begin
                  state_q   <= ST_CLEAR;
                  clr_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
               if (clr_cnt_q == '1) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;
   assign busy     = busy_q;

   sdp_ram #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .OUT_NEW_DATA (0),
      .IMPORT       (0)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .d     (ram_d),
      .re    (ram_re),
      .raddr (ram_raddr),
      .q     (rd_data)
   );

endmodule
